cpu_clk_ctrl: RTL and testbench
===============================

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divide-ratio input.
REQ-002 SHALL have parameter CNT_W, default 16, width of the issued-enable counter.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port div  in  DIV_W  divide ratio: one enable per div+1 clk cycles.
REQ-006 SHALL have port run  in  1  level; continuous run request.
REQ-007 SHALL have port step_req  in  1  single-step request; acts on its rising edge only.
REQ-008 SHALL have port burst_req  in  1  one-cycle pulse; starts a burst of burst_len enables.
REQ-009 SHALL have port burst_len  in  8  number of enables in a burst.
REQ-010 SHALL have port halt  in  1  level; synchronous abort/hold; highest priority.
REQ-011 SHALL have port mclk_en  out  1  registered one-cycle clock enable to the CPU pipeline.
REQ-012 SHALL have port state  out  2  current state: IDLE=00, RUN=01, STEP=10, BURST=11.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-014 SHALL have port done  out  1  registered one-cycle pulse on normal STEP/BURST completion.
REQ-015 SHALL have port en_cnt  out  CNT_W  total mclk_en pulses issued.

Function
REQ-016 IDLE SHALL: halt -> stay IDLE; else run=1 -> RUN; else step_req rising edge -> STEP; else burst_req=1 and burst_len!=0 -> BURST; else stay IDLE.
REQ-017 On leaving IDLE, div SHALL be latched (div_l), burst_len latched (rem), divider counter cleared to 0; changes to div/burst_len while busy SHALL be ignored.
REQ-018 In RUN/STEP/BURST the divider counter SHALL increment each cycle; when it equals div_l it SHALL wrap to 0 and mclk_en SHALL be high for the following cycle.
REQ-019 Latency: state entered at edge k -> first mclk_en high cycle begins at edge k+div_l+1; then every div_l+1 cycles (div_l=0 -> mclk_en high every cycle).
REQ-020 RUN SHALL return to IDLE on the edge that samples run=0 or halt=1; no further mclk_en after that edge; done SHALL NOT pulse.
REQ-021 STEP SHALL issue exactly one mclk_en and return to IDLE on the same edge that sets mclk_en; done high on that same edge.
REQ-022 BURST SHALL decrement rem per mclk_en and return to IDLE, with done high, on the edge setting the mclk_en that takes rem to 0.
REQ-023 halt=1 in STEP or BURST SHALL return to IDLE at that edge with no mclk_en and no done; pending count discarded.
REQ-024 step_req, burst_req and run edges while busy SHALL be ignored, not queued; burst_req with burst_len=0 SHALL be ignored.
REQ-025 step_req rising edge SHALL be detected against a registered previous value; holding step_req high SHALL give one step only.
REQ-026 en_cnt SHALL increment by 1 per mclk_en pulse, wrapping from all-ones to 0.
REQ-027 Simultaneous halt and divider expiry SHALL resolve to halt: no mclk_en.

Reset
REQ-028 reset=1 at an edge SHALL force state=IDLE, mclk_en=0, done=0, busy=0, en_cnt=0, divider counter=0, rem=0, div_l=0, step_prev=1, overriding all other inputs, including mid-RUN/STEP/BURST.
REQ-029 After reset release, step_req held high through reset SHALL NOT trigger a step until it falls and rises again.

Verification
REQ-030 div=0, run=1 for 10 cycles then run=0 -> mclk_en high 10 consecutive cycles starting one cycle after RUN entry, en_cnt=10, done never pulses.
REQ-031 div=3, one step_req rise -> STEP for 4 cycles, single mclk_en on 4th edge, done pulses same cycle, state IDLE, en_cnt=1.
REQ-032 div=1, burst_len=5, burst_req pulse -> 5 mclk_en pulses spaced 2 cycles, done with 5th, then IDLE; step_req during burst ignored.
REQ-033 div=2, burst_len=8; halt after 3rd pulse -> IDLE immediately, en_cnt=3, no done; burst_len=0 request -> stays IDLE.
REQ-034 reset asserted mid-BURST with step_req held high -> all outputs 0, state IDLE; no step after release until step_req toggles.
REQ-035 en_cnt preloaded by 65535 pulses (div=0, run) then one more -> en_cnt wraps to 0.

Source files
------------

// File: rtl/cpu_clk_ctrl_if.sv
// rtl/cpu_clk_ctrl_if.sv - request/status bundle between a CPU clock-enable controller and its driver
interface cpu_clk_ctrl_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic [DIV_W-1:0] div;
  logic             run;
  logic             step_req;
  logic             burst_req;
  logic [7:0]       burst_len;
  logic             halt;
  logic             mclk_en;
  logic [1:0]       state;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] en_cnt;

  modport master (
    output div, run, step_req, burst_req, burst_len, halt,
    input  mclk_en, state, busy, done, en_cnt
  );

  modport slave (
    input  div, run, step_req, burst_req, burst_len, halt,
    output mclk_en, state, busy, done, en_cnt
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - divided clock-enable generator with run, single-step and burst modes
module cpu_clk_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  cpu_clk_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BURST = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] r_div_l;
  logic [DIV_W-1:0] r_cnt;
  logic [7:0]       r_rem;
  logic             r_mclk_en;
  logic             r_done;
  logic             r_step_prev;
  logic [CNT_W-1:0] r_en_cnt;

  logic w_step_rise;
  logic w_expire;
  logic w_leave_idle;
  logic w_enter_idle;
  logic w_mclk_en_nxt;
  logic w_done_nxt;

  assign w_step_rise  = bus.step_req & ~r_step_prev;
  assign w_expire     = (r_state != S_IDLE) && (r_cnt == r_div_l);
  assign w_leave_idle = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);
  assign w_enter_idle = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // halt overrides every state, including a divider expiry in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (bus.halt) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run)                                     w_state_nxt = S_RUN;
          else if (w_step_rise)                            w_state_nxt = S_STEP;
          else if (bus.burst_req && (bus.burst_len != 8'd0)) w_state_nxt = S_BURST;
        end
        S_RUN:   if (!bus.run)                        w_state_nxt = S_IDLE;
        S_STEP:  if (w_expire)                        w_state_nxt = S_IDLE;
        S_BURST: if (w_expire && (r_rem == 8'd1))     w_state_nxt = S_IDLE;
        default:                                      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mclk_en_nxt = w_expire && !bus.halt;
    w_done_nxt    = w_mclk_en_nxt &&
                    ((r_state == S_STEP) || ((r_state == S_BURST) && (r_rem == 8'd1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mclk_en   <= 1'b0;
      r_done      <= 1'b0;
      r_en_cnt    <= '0;
      r_cnt       <= '0;
      r_rem       <= 8'd0;
      r_div_l     <= '0;
      r_step_prev <= 1'b1;
    end else begin
      r_step_prev <= bus.step_req;
      r_mclk_en   <= w_mclk_en_nxt;
      r_done      <= w_done_nxt;
      r_en_cnt    <= r_en_cnt + CNT_W'(w_mclk_en_nxt);
      if (w_leave_idle) begin
        r_div_l <= bus.div;
        r_rem   <= bus.burst_len;
        r_cnt   <= '0;
      end else if ((r_state == S_IDLE) || w_enter_idle) begin
        r_cnt <= '0;
        r_rem <= 8'd0;
      end else begin
        r_cnt <= w_expire ? '0 : r_cnt + 1'b1;
        if ((r_state == S_BURST) && w_mclk_en_nxt) begin
          r_rem <= r_rem - 8'd1;
        end
      end
    end
  end

  assign bus.mclk_en = r_mclk_en;
  assign bus.state   = r_state;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.en_cnt  = r_en_cnt;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - directed self-checking bench for cpu_clk_ctrl
module tb_cpu_clk_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   pulses;
  int   dones;

  cpu_clk_ctrl_if #(.DIV_W(8), .CNT_W(16)) bus ();

  cpu_clk_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mclk_en) pulses++;
      if (bus.done) dones++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; pulses = 0; dones = 0;
    reset = 1'b1;
    bus.div = 8'd0; bus.run = 1'b0; bus.step_req = 1'b0;
    bus.burst_req = 1'b0; bus.burst_len = 8'd0; bus.halt = 1'b0;
    @(negedge clk);
    run_cycles(2);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_mclk_en", 32'(bus.mclk_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_en_cnt", 32'(bus.en_cnt), 32'd0);
    reset = 1'b0;
    run_cycles(1);

    // continuous run, div=0
    bus.div = 8'd0; bus.run = 1'b1;
    run_cycles(1);
    check("run_entry_state", 32'(bus.state), 32'd1);
    check("run_entry_mclk", 32'(bus.mclk_en), 32'd0);
    pulses = 0; dones = 0;
    run_cycles(9);
    check("run_pulses9", 32'(pulses), 32'd9);
    bus.run = 1'b0;
    run_cycles(1);
    check("run_pulses10", 32'(pulses), 32'd10);
    check("run_exit_state", 32'(bus.state), 32'd0);
    check("run_en_cnt", 32'(bus.en_cnt), 32'd10);
    run_cycles(1);
    check("run_after_mclk", 32'(bus.mclk_en), 32'd0);
    check("run_no_done", 32'(dones), 32'd0);

    // single step, div=3, step_req held high
    bus.div = 8'd3; bus.step_req = 1'b1;
    pulses = 0; dones = 0;
    run_cycles(1);
    check("step_state", 32'(bus.state), 32'd2);
    run_cycles(3);
    check("step_wait_pulses", 32'(pulses), 32'd0);
    check("step_wait_state", 32'(bus.state), 32'd2);
    run_cycles(1);
    check("step_mclk", 32'(bus.mclk_en), 32'd1);
    check("step_done", 32'(bus.done), 32'd1);
    check("step_idle", 32'(bus.state), 32'd0);
    check("step_en_cnt", 32'(bus.en_cnt), 32'd11);
    pulses = 0;
    run_cycles(6);
    check("step_hold_no_retrigger", 32'(pulses), 32'd0);
    check("step_hold_state", 32'(bus.state), 32'd0);
    bus.step_req = 1'b0;
    run_cycles(1);

    // burst of 5 at div=1, step request during burst is ignored
    bus.div = 8'd1; bus.burst_len = 8'd5; bus.burst_req = 1'b1;
    run_cycles(1);
    bus.burst_req = 1'b0; bus.step_req = 1'b1;
    check("burst_state", 32'(bus.state), 32'd3);
    pulses = 0; dones = 0;
    run_cycles(1);
    check("burst_gap_mclk", 32'(bus.mclk_en), 32'd0);
    run_cycles(1);
    check("burst_first_mclk", 32'(bus.mclk_en), 32'd1);
    run_cycles(7);
    check("burst_pulses4", 32'(pulses), 32'd4);
    check("burst_no_early_done", 32'(dones), 32'd0);
    check("burst_still_busy", 32'(bus.state), 32'd3);
    run_cycles(1);
    check("burst_last_mclk", 32'(bus.mclk_en), 32'd1);
    check("burst_done", 32'(bus.done), 32'd1);
    check("burst_idle", 32'(bus.state), 32'd0);
    pulses = 0;
    run_cycles(4);
    check("burst_step_ignored", 32'(pulses), 32'd0);
    check("burst_en_cnt", 32'(bus.en_cnt), 32'd16);
    bus.step_req = 1'b0;

    // burst of 8 at div=2 aborted by halt after the third pulse
    bus.div = 8'd2; bus.burst_len = 8'd8; bus.burst_req = 1'b1;
    run_cycles(1);
    bus.burst_req = 1'b0;
    pulses = 0; dones = 0;
    run_cycles(9);
    check("halt_pre_pulses", 32'(pulses), 32'd3);
    bus.halt = 1'b1;
    run_cycles(1);
    check("halt_state", 32'(bus.state), 32'd0);
    check("halt_mclk", 32'(bus.mclk_en), 32'd0);
    check("halt_no_done", 32'(dones), 32'd0);
    check("halt_en_cnt", 32'(bus.en_cnt), 32'd19);
    bus.halt = 1'b0;
    bus.burst_len = 8'd0; bus.burst_req = 1'b1;
    run_cycles(1);
    bus.burst_req = 1'b0;
    check("burst_len0_idle", 32'(bus.state), 32'd0);

    // halt coinciding with divider expiry
    bus.div = 8'd1; bus.burst_len = 8'd3; bus.burst_req = 1'b1;
    run_cycles(1);
    bus.burst_req = 1'b0;
    run_cycles(1);
    bus.halt = 1'b1;
    run_cycles(1);
    check("halt_expiry_mclk", 32'(bus.mclk_en), 32'd0);
    check("halt_expiry_state", 32'(bus.state), 32'd0);
    check("halt_expiry_en_cnt", 32'(bus.en_cnt), 32'd19);
    bus.halt = 1'b0;

    // reset mid-burst with step_req held high
    bus.div = 8'd1; bus.burst_len = 8'd5; bus.burst_req = 1'b1;
    run_cycles(1);
    bus.burst_req = 1'b0; bus.step_req = 1'b1;
    run_cycles(3);
    reset = 1'b1;
    run_cycles(1);
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_mclk", 32'(bus.mclk_en), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_en_cnt", 32'(bus.en_cnt), 32'd0);
    reset = 1'b0;
    pulses = 0;
    run_cycles(3);
    check("postrst_no_step", 32'(bus.state), 32'd0);
    check("postrst_no_pulse", 32'(pulses), 32'd0);
    bus.step_req = 1'b0;
    run_cycles(1);
    bus.step_req = 1'b1;
    run_cycles(1);
    check("postrst_step_state", 32'(bus.state), 32'd2);
    run_cycles(2);
    check("postrst_step_mclk", 32'(bus.mclk_en), 32'd1);
    check("postrst_step_en_cnt", 32'(bus.en_cnt), 32'd1);
    bus.step_req = 1'b0;

    // en_cnt wrap after 65536 pulses
    reset = 1'b1;
    run_cycles(1);
    reset = 1'b0;
    bus.div = 8'd0; bus.run = 1'b1;
    pulses = 0;
    run_cycles(65535);
    bus.run = 1'b0;
    run_cycles(1);
    check("wrap_pulses", 32'(pulses), 32'd65535);
    check("wrap_preload", 32'(bus.en_cnt), 32'hFFFF);
    bus.run = 1'b1;
    run_cycles(1);
    bus.run = 1'b0;
    run_cycles(1);
    check("wrap_zero", 32'(bus.en_cnt), 32'd0);
    check("wrap_state", 32'(bus.state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
